fetch_align_unit: RTL

FETCH_ALIGN_UNIT -- requirements
Module: fetch_align_unit

---
 rtl/fetch_align_unit.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/fetch_align_unit.sv
`default_nettype none
// fetch_align_unit: PC generation, instruction fetch and 16/32-bit alignment into the IF/ID register.
// Define FETCH_RVC_EN to enable compressed-instruction support (halfword buffer + REFILL state).
module fetch_align_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        Stall_i,
  input  logic        Flush_i,
  input  logic        Redirect_i,
  input  logic [31:0] Redirect_pc_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  output logic [31:0] IFID_instr_o,
  output logic [31:0] IFID_pc_o,
  output logic        IFID_valid_o,
  output logic        IFID_is_c_o
);

  logic [31:0] pc;
  logic [31:0] pc_nxt;
  logic [31:0] redirect_pc;
  logic [31:0] step_instr;
  logic        step_valid;
  logic        step_c;

`ifdef FETCH_RVC_EN
  typedef enum logic [0:0] {
    RUN    = 1'b0,
    REFILL = 1'b1
  } state_t;

  state_t      state;
  logic [15:0] half_buf;
  logic [15:0] half_buf_nxt;
  logic        half_buf_v;
  logic        half_buf_v_nxt;
  logic        lo_is_c;
  logic        buf_is_c;

  assign redirect_pc = Redirect_pc_i & 32'hFFFF_FFFE;
  assign lo_is_c     = (imem_data_i[1:0] != 2'b11);
  assign buf_is_c    = (half_buf[1:0] != 2'b11);

  // Upper half of an odd-aligned instruction lives in the next word.
  always_comb begin
    imem_addr_o = {pc[31:2], 2'b00};
    if (state == RUN && pc[1] && half_buf_v)
      imem_addr_o = {pc[31:2] + 30'd1, 2'b00};
  end

  always_comb begin
    step_instr     = NOP_INSTR;
    step_valid     = 1'b0;
    step_c         = 1'b0;
    pc_nxt         = pc;
    half_buf_nxt   = half_buf;
    half_buf_v_nxt = half_buf_v;
    if (state == REFILL || (pc[1] && !half_buf_v)) begin
      half_buf_nxt   = imem_data_i[31:16];
      half_buf_v_nxt = 1'b1;
    end else if (!pc[1]) begin
      step_valid = 1'b1;
      if (lo_is_c) begin
        step_instr     = {16'h0000, imem_data_i[15:0]};
        step_c         = 1'b1;
        pc_nxt         = pc + 32'd2;
        half_buf_nxt   = imem_data_i[31:16];
        half_buf_v_nxt = 1'b1;
      end else begin
        step_instr     = imem_data_i;
        pc_nxt         = pc + 32'd4;
        half_buf_v_nxt = 1'b0;
      end
    end else begin
      step_valid = 1'b1;
      if (buf_is_c) begin
        step_instr     = {16'h0000, half_buf};
        step_c         = 1'b1;
        pc_nxt         = pc + 32'd2;
        half_buf_v_nxt = 1'b0;
      end else begin
        step_instr     = {imem_data_i[15:0], half_buf};
        pc_nxt         = pc + 32'd4;
        half_buf_nxt   = imem_data_i[31:16];
        half_buf_v_nxt = 1'b1;
      end
    end
  end
`else
  assign redirect_pc = Redirect_pc_i & 32'hFFFF_FFFC;
  assign imem_addr_o = {pc[31:2], 2'b00};
  assign step_instr  = imem_data_i;
  assign step_valid  = 1'b1;
  assign step_c      = 1'b0;
  assign pc_nxt      = pc + 32'd4;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc           <= RESET_PC & 32'hFFFF_FFFE;
`ifdef FETCH_RVC_EN
      state        <= RUN;
      half_buf     <= 16'h0000;
      half_buf_v   <= 1'b0;
`endif
      IFID_instr_o <= NOP_INSTR;
      IFID_pc_o    <= RESET_PC;
      IFID_valid_o <= 1'b0;
      IFID_is_c_o  <= 1'b0;
    end else begin
      if (Redirect_i) begin
        pc         <= redirect_pc;
`ifdef FETCH_RVC_EN
        half_buf_v <= 1'b0;
        state      <= Redirect_pc_i[1] ? REFILL : RUN;
`endif
      end else if (!Stall_i) begin
        pc         <= pc_nxt;
`ifdef FETCH_RVC_EN
        half_buf   <= half_buf_nxt;
        half_buf_v <= half_buf_v_nxt;
        state      <= RUN;
`endif
      end

      if (Flush_i) begin
        IFID_instr_o <= NOP_INSTR;
        IFID_pc_o    <= pc;
        IFID_valid_o <= 1'b0;
        IFID_is_c_o  <= 1'b0;
      end else if (!Stall_i) begin
        IFID_instr_o <= step_instr;
        IFID_pc_o    <= pc;
        IFID_valid_o <= step_valid;
        IFID_is_c_o  <= step_c;
      end
    end
  end

endmodule
`default_nettype wire
